// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// SPI Mode 0 (CPOL=0, CPHA=0, MSB first) responder that oversamples the
// master's sclk / spi_cs_l / mosi in the local clk domain.
//
// Ports
//   clk        : system clock, all state on its rising edge
//   reset      : synchronous, active-high reset
//   sclk       : serial clock from the master (asynchronous)
//   spi_cs_l   : active-low chip select from the master (asynchronous)
//   mosi       : serial data from the master (asynchronous)
//   tx_data    : reply word, captured when a frame starts
//   miso       : serial reply bit, 0 outside an active shift phase
//   dataout    : last completed received word
//   data_valid : one-cycle strobe when dataout updates
//   frame_err  : one-cycle strobe on an aborted frame or an overrun bit
//   busy       : high while the receiver is not idle
module spi_slave_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             spi_cs_l,
  input  logic             mosi,
  input  logic [WIDTH-1:0] tx_data,
  output logic             miso,
  output logic [WIDTH-1:0] dataout,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic sclk_s1_r, sclk_s2_r, sclk_d3_r;
  logic cs_s1_r, cs_s2_r, cs_d3_r;
  logic mosi_s1_r, mosi_s2_r;
  logic [2:0] prime_r;

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

  logic load_tx_s, rx_shift_s, tx_shift_s, abort_s, overrun_s, done_s;
  logic done_r;

  logic [WIDTH-1:0] rx_sr_r;
  logic [WIDTH-2:0] tx_sr_r;
  logic [CNT_W-1:0] cnt_r;

  logic             miso_r;
  logic [WIDTH-1:0] dataout_r;
  logic             data_valid_r;
  logic             frame_err_r;
  logic             busy_r;

  // Input synchronizers, edge-detect delay stage and post-reset priming flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_r <= 1'b0;
      sclk_s2_r <= 1'b0;
      sclk_d3_r <= 1'b0;
      cs_s1_r   <= 1'b1;
      cs_s2_r   <= 1'b1;
      cs_d3_r   <= 1'b1;
      mosi_s1_r <= 1'b0;
      mosi_s2_r <= 1'b0;
      prime_r   <= 3'b000;
    end else begin
      sclk_s1_r <= sclk;
      sclk_s2_r <= sclk_s1_r;
      sclk_d3_r <= sclk_s2_r;
      cs_s1_r   <= spi_cs_l;
      cs_s2_r   <= cs_s1_r;
      cs_d3_r   <= cs_s2_r;
      mosi_s1_r <= mosi;
      mosi_s2_r <= mosi_s1_r;
      prime_r   <= {prime_r[1:0], 1'b1};
    end
  end

  assign sclk_rise_s = sclk_s2_r & ~sclk_d3_r;
  assign sclk_fall_s = ~sclk_s2_r & sclk_d3_r;
  assign cs_rise_s   = cs_s2_r & ~cs_d3_r;
  // The cs chain resets to "inactive"; a cs that is already low when reset
  // drops would otherwise look like a fresh fall. Only trust a fall once both
  // compared stages hold real post-reset samples.
  assign cs_fall_s   = ~cs_s2_r & cs_d3_r & prime_r[2];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    load_tx_s    = 1'b0;
    rx_shift_s   = 1'b0;
    tx_shift_s   = 1'b0;
    abort_s      = 1'b0;
    overrun_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          load_tx_s    = 1'b1;
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        // cs rise beats a coincident sclk rise, even on the final bit.
        if (cs_rise_s) begin
          abort_s      = 1'b1;
          next_state_s = IDLE;
        end else if (sclk_rise_s) begin
          rx_shift_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            done_s       = 1'b1;
            next_state_s = HOLD;
          end else begin
            next_state_s = SHIFT;
          end
        end else if (sclk_fall_s) begin
          tx_shift_s   = 1'b1;
          next_state_s = SHIFT;
        end else begin
          next_state_s = SHIFT;
        end
      end
      HOLD: begin
        if (sclk_rise_s) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = 1'b0;
        end
        if (cs_rise_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Shift registers, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sr_r      <= '0;
      tx_sr_r      <= '0;
      cnt_r        <= '0;
      done_r       <= 1'b0;
      miso_r       <= 1'b0;
      dataout_r    <= '0;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (load_tx_s) begin
        tx_sr_r <= tx_data[WIDTH-2:0];
        miso_r  <= tx_data[WIDTH-1];
      end else if (next_state_s != SHIFT) begin
        miso_r <= 1'b0;
      end else if (tx_shift_s) begin
        miso_r  <= tx_sr_r[WIDTH-2];
        tx_sr_r <= tx_sr_r << 1;
      end else begin
        miso_r <= miso_r;
      end

      if (load_tx_s) begin
        rx_sr_r <= '0;
        cnt_r   <= '0;
      end else if (rx_shift_s) begin
        rx_sr_r <= {rx_sr_r[WIDTH-2:0], mosi_s2_r};
        if (cnt_r != CNT_FULL) begin
          cnt_r <= cnt_r + 1'b1;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        rx_sr_r <= rx_sr_r;
      end

      // The last bit lands in rx_sr on the done cycle; publish one cycle later.
      done_r <= done_s;
      if (done_r) begin
        dataout_r <= rx_sr_r;
      end else begin
        dataout_r <= dataout_r;
      end
      data_valid_r <= done_r;
      frame_err_r  <= abort_s | overrun_s;
      busy_r       <= (next_state_s != IDLE);
    end
  end

  assign miso       = miso_r;
  assign dataout    = dataout_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI responder (Mode 0, CPOL=0/CPHA=0, MSB first) for the master driven by `datain`/`spi_cs*_l`/`sclk*`. It sits on one chip-select branch and oversamples the master's `sclk`, `spi_cs_l` and `mosi` in the local `clk` domain. It assembles `WIDTH`-bit words and presents each with a one-cycle valid strobe. It also shifts a reply word out on `miso`.

## Interface
- `WIDTH`, 16: frame length in bits (≥2).
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sclk` input 1: serial clock from the master; asynchronous to `clk`.
- `spi_cs_l` input 1: active-low chip select from the master; asynchronous.
- `mosi` input 1: serial data from the master; asynchronous.
- `tx_data` input WIDTH: reply word, captured at frame start.
- `miso` output 1: serial reply to the master.
- `dataout` output WIDTH: last completed received word; held until the next completion.
- `data_valid` output 1: one-cycle strobe when `dataout` updates.
- `frame_err` output 1: one-cycle strobe on an aborted frame or an overrun.
- `busy` output 1: high while the FSM is not in IDLE.

## Operation
- Synchronizers: `sclk`, `spi_cs_l` and `mosi` each pass through a 2-flop synchronizer.
- Edge detection: a third register on each of the synced `sclk` and `spi_cs_l` gives single-cycle rise/fall pulses.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - Synced cs fall → load `tx_data` into the tx shift register.
  - Clear the bit counter and go to SHIFT.
  - `miso` = `tx_data[WIDTH-1]` from the cycle after the cs fall.
- SHIFT:
  - On each synced sclk rise: `rx_sr <= {rx_sr[WIDTH-2:0], mosi_sync}` and increment the bit counter.
  - On each synced sclk fall: shift the tx register left; `miso` = new MSB.
  - When the rise that brings the counter to WIDTH occurs: go to HOLD.
  - In the next cycle after that rise: `dataout` = the assembled word and `data_valid` = 1 for one cycle.
  - Synced cs rise before WIDTH bits: `frame_err` pulses, `dataout` is unchanged, no `data_valid`, go to IDLE.
- HOLD: waits for the synced cs rise, then goes to IDLE.
  - An sclk rise in HOLD is an overrun: pulse `frame_err` once per extra rise. The extra bits are discarded and `dataout` is kept.
  - `miso` = 0 in HOLD.
- Back-to-back frames: the master must raise cs between words. If cs stays low, all further edges are overruns.
- Simultaneous synced cs rise and sclk rise in SHIFT: cs wins. The frame is aborted even if that edge would have been bit WIDTH.
- `miso` = 0 in IDLE. No tristate; the top level muxes `miso` by chip select.
- The bit counter is $clog2(WIDTH+1) bits wide and never wraps; it saturates at WIDTH.

## Timing
- Values after `reset`: `miso`=0, `dataout`=0, `data_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, shift registers=0.
- Synchronizer outputs reset to their inactive levels: sclk=0, cs_l=1, mosi=0.
- `reset` asserted mid-frame takes effect on the next `clk` edge: the partial word is dropped with no strobe.
  - If cs is still low when `reset` is released, the FSM stays in IDLE until a fresh cs fall.
- Input to internal edge pulse: 3 `clk` cycles.
- `data_valid` rises 4 `clk` edges after the physical last sclk rise.
- `miso` changes 3–4 `clk` cycles after each physical sclk fall.
- Required master timing:
  - sclk high and low phases ≥ 4 `clk` periods each.
  - cs fall to first sclk rise ≥ 4 `clk` periods.
  - Last sclk rise to cs rise ≥ 4 `clk` periods.
- `busy` is high from the cycle after the synced cs fall through the cycle of the return to IDLE.

## Test plan
- Receive: after reset, master sends 16'hA569 (sclk = clk/8) → `dataout`=16'hA569; `data_valid` is high for exactly 1 cycle; `frame_err` stays 0.
- Transmit: `tx_data`=16'h3C5A, any mosi word → bits sampled on `miso` at sclk rises read 0011_1100_0101_1010; `miso`=0 after cs rises.
- Abort: cs raised after 7 bits → `frame_err` pulses once; `dataout` keeps its previous value; no `data_valid`; the next full frame of 16'h1234 is received correctly.
- Overrun: 18 sclk rises in one cs-low window sending 16'hFFFF then 2 bits → `data_valid` once with 16'hFFFF; `frame_err` pulses twice.
- Reset mid-frame: `reset` pulsed after 9 bits with cs held low, then cs rises and a new frame 16'h00FF is sent → no strobe from the first frame; `dataout`=16'h00FF after the second.
- Back-to-back: 16'hA569 then 16'h5A96 with a 5-clk cs-high gap → two `data_valid` pulses with the matching values, in order.
